dtw_ref_streamer: RTL and testbench

//  Downstream consumer of the reference-memory core in DTW_READ mode. Drives the reference read address,

---
 rtl/dtw_pkg.sv | 20 ++
 rtl/dtw_ref_skid_fifo.sv | 61 ++++++
 rtl/dtw_ref_streamer.sv | 192 +++++++++++++++++++
 tb/tb_dtw_ref_streamer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// Purpose: shared types for the DTW reference streamer (FSM states, per-sample tags).
// Latency: n/a (types only).
// Backpressure: n/a.
package dtw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } dtw_state_t;

  // Tags travel with each read through the in-flight pipe and the skid FIFO.
  typedef struct packed {
    logic last_pass;
    logic last_job;
  } smp_tag_t;

  localparam int SMP_TAG_W = $bits(smp_tag_t);

endpackage

// File: rtl/dtw_ref_skid_fifo.sv
// Purpose: small synchronous FIFO absorbing read returns ahead of the sample stream.
// Latency: push visible on the read side one cycle later (storage is registered).
// Backpressure: none of its own; producer must not push when full, pop ignored when empty.
// Ports: clk/rst_n, flush (sync clear), push/push_dat, pop/pop_dat, empty, full, count.
module dtw_ref_skid_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign pop_dat = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dtw_ref_streamer.sv
// Purpose: scans reference memory 0..len-1 for num_passes passes and streams tagged samples to the PE array.
// Latency: first sample valid RD_LATENCY+1 cycles after an accepted start; then one sample/cycle.
// Backpressure: credit-limited read issue into a skid FIFO; nothing is dropped while ready is low.
// Ports: start/abort control, ref_len/num_passes job config, ref_addr/ref_data to the ref core,
//        smp_* valid/ready stream with last-of-pass/last-of-job tags, busy/done/err_not_loaded status.
module dtw_ref_streamer
  import dtw_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH       = 32,
  parameter int REFMEM_PTR_WIDTH = 20,
  parameter int PASS_WIDTH       = 16,
  parameter int RD_LATENCY       = 2,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        start_in,
  input  logic                        abort_in,
  input  logic [ADDR_WIDTH-1:0]       ref_len_in,
  input  logic [PASS_WIDTH-1:0]       num_passes_in,
  input  logic                        ref_load_done_in,
  output logic [REFMEM_PTR_WIDTH-1:0] ref_addr_out,
  input  logic [DATA_WIDTH-1:0]       ref_data_in,
  output logic [DATA_WIDTH-1:0]       smp_data_out,
  output logic                        smp_valid_out,
  input  logic                        smp_ready_in,
  output logic                        smp_last_pass_out,
  output logic                        smp_last_job_out,
  output logic                        busy_out,
  output logic                        done_out,
  output logic                        err_not_loaded_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int FW    = DATA_WIDTH + SMP_TAG_W;

  dtw_state_t                  state_q, state_d;
  logic [REFMEM_PTR_WIDTH-1:0] addr_q, len_m1_q, len_lo;
  logic [PASS_WIDTH-1:0]       pass_q, passes_m1_q;
  logic [RD_LATENCY-1:0]       pipe_vld_q;
  smp_tag_t                    pipe_tag_q [RD_LATENCY];
  logic                        done_q, err_q;
  logic                        issue, load, done_d, err_set, err_clr;
  logic                        last_pass_now, last_job_now;
  logic [CNT_W-1:0]            inflight, fifo_cnt;
  logic                        credit_ok;
  logic                        fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [FW-1:0]               fifo_dout;
  smp_tag_t                    out_tag;
  logic                        unused_len_hi;

  // Only the low pointer bits of the length address the reference memory.
  assign len_lo        = ref_len_in[REFMEM_PTR_WIDTH-1:0];
  assign unused_len_hi = ^ref_len_in[ADDR_WIDTH-1:REFMEM_PTR_WIDTH];

  assign last_pass_now = (addr_q == len_m1_q);
  assign last_job_now  = last_pass_now && (pass_q == passes_m1_q);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(pipe_vld_q[i]);
    end
  end

  // Reserve a FIFO slot for every read still in the memory pipe, so a return can never find it full.
  assign credit_ok = ({1'b0, fifo_cnt} + {1'b0, inflight}) < (CNT_W+1)'(FIFO_DEPTH);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    load    = 1'b0;
    done_d  = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in && !abort_in) begin
          if (!ref_load_done_in) begin
            err_set = 1'b1;
          end else begin
            err_clr = 1'b1;
            if (len_lo == '0 || num_passes_in == '0) begin
              done_d = 1'b1;
            end else begin
              load    = 1'b1;
              state_d = ST_ISSUE;
            end
          end
        end
      end
      ST_ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (last_job_now) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (inflight == '0 && fifo_empty) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_in) begin
      state_d = ST_IDLE;
      issue   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr_q      <= '0;
      len_m1_q    <= '0;
      pass_q      <= '0;
      passes_m1_q <= '0;
      pipe_vld_q  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_tag_q[i] <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= done_d;
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;

      // Address advances only after an issue, and not after the job's final read,
      // so it keeps showing the last issued address once the job is done.
      if (load) begin
        addr_q      <= '0;
        pass_q      <= '0;
        len_m1_q    <= len_lo - REFMEM_PTR_WIDTH'(1);
        passes_m1_q <= num_passes_in - PASS_WIDTH'(1);
      end else if (issue && !last_job_now) begin
        if (last_pass_now) begin
          addr_q <= '0;
          pass_q <= pass_q + PASS_WIDTH'(1);
        end else begin
          addr_q <= addr_q + REFMEM_PTR_WIDTH'(1);
        end
      end

      if (abort_in) begin
        pipe_vld_q <= '0;
      end else begin
        pipe_vld_q[0] <= issue;
        for (int i = 1; i < RD_LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
      end
      pipe_tag_q[0] <= '{last_pass: last_pass_now, last_job: last_job_now};
      for (int i = 1; i < RD_LATENCY; i++) pipe_tag_q[i] <= pipe_tag_q[i-1];
    end
  end

  assign fifo_push = pipe_vld_q[RD_LATENCY-1] & ~abort_in;
  assign fifo_pop  = smp_valid_out & smp_ready_in;

  dtw_ref_skid_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .flush    (abort_in),
    .push     (fifo_push),
    .push_dat ({pipe_tag_q[RD_LATENCY-1], ref_data_in}),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dout),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_cnt)
  );

  a_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_n_in) !(fifo_push && fifo_full));

  assign out_tag            = smp_tag_t'(fifo_dout[FW-1:DATA_WIDTH]);
  assign smp_valid_out      = ~fifo_empty;
  assign smp_data_out       = smp_valid_out ? fifo_dout[DATA_WIDTH-1:0] : '0;
  assign smp_last_pass_out  = smp_valid_out & out_tag.last_pass;
  assign smp_last_job_out   = smp_valid_out & out_tag.last_job;
  assign ref_addr_out       = addr_q;
  assign busy_out           = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done_out           = done_q;
  assign err_not_loaded_out = err_q;

endmodule

// File: tb/tb_dtw_ref_streamer.sv
module tb_dtw_ref_streamer;

  typedef struct packed {
    logic [15:0] d;
    logic        lp;
    logic        lj;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        start_in = 1'b0;
  logic        abort_in = 1'b0;
  logic [31:0] ref_len_in = '0;
  logic [15:0] num_passes_in = '0;
  logic        ref_load_done_in = 1'b1;
  logic [19:0] ref_addr_out;
  logic [15:0] ref_data_in = '0;
  logic [15:0] smp_data_out;
  logic        smp_valid_out;
  logic        smp_ready_in = 1'b0;
  logic        smp_last_pass_out;
  logic        smp_last_job_out;
  logic        busy_out;
  logic        done_out;
  logic        err_not_loaded_out;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic        stab_pend = 1'b0;
  logic [17:0] stab_dat = '0;
  logic [19:0] core_addr_q = '0;

  dtw_ref_streamer dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n_in),
    .start_in           (start_in),
    .abort_in           (abort_in),
    .ref_len_in         (ref_len_in),
    .num_passes_in      (num_passes_in),
    .ref_load_done_in   (ref_load_done_in),
    .ref_addr_out       (ref_addr_out),
    .ref_data_in        (ref_data_in),
    .smp_data_out       (smp_data_out),
    .smp_valid_out      (smp_valid_out),
    .smp_ready_in       (smp_ready_in),
    .smp_last_pass_out  (smp_last_pass_out),
    .smp_last_job_out   (smp_last_job_out),
    .busy_out           (busy_out),
    .done_out           (done_out),
    .err_not_loaded_out (err_not_loaded_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference core: address register then memory register; mem[a] = 16'h5A00 + a.
  always @(posedge clk) begin
    core_addr_q <= ref_addr_out;
    ref_data_in <= 16'h5A00 + core_addr_q[15:0];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expectation on every handshake, and checks hold-stability under stall.
  always @(negedge clk) begin
    if (!rst_n_in) begin
      stab_pend = 1'b0;
    end else begin
      if (done_out) done_cnt++;
      if (stab_pend)
        chk("hold_stable", {smp_valid_out, smp_data_out, smp_last_pass_out, smp_last_job_out},
            {1'b1, stab_dat});
      if (smp_valid_out && smp_ready_in) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_sample: got data %0h, expected no sample", smp_data_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sample", {smp_data_out, smp_last_pass_out, smp_last_job_out}, mon_e);
        end
      end
      stab_pend = smp_valid_out && !smp_ready_in && !abort_in;
      stab_dat  = {smp_data_out, smp_last_pass_out, smp_last_job_out};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input int len, input int passes);
    for (int p = 0; p < passes; p++) begin
      for (int a = 0; a < len; a++) begin
        exp_t e;
        e.d  = 16'h5A00 + 16'(a);
        e.lp = (a == len - 1);
        e.lj = (a == len - 1) && (p == passes - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic start_job(input logic [31:0] len, input logic [15:0] passes);
    ref_len_in    = len;
    num_passes_in = passes;
    start_in      = 1'b1;
    tick();
    start_in      = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_out) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout after %0d cycles, %0d samples outstanding, required 0", nm, n, exp_q.size());
    end
    tick();
    tick();
  endtask

  function automatic logic [63:0] outs();
    return {ref_addr_out, smp_data_out, smp_valid_out, smp_last_pass_out, smp_last_job_out,
            busy_out, done_out, err_not_loaded_out};
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0, s0, first, n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 64'd0);
    rst_n_in = 1'b1;
    tick();

    // len=5 (upper length bits set and ignored), passes=2, ready held high
    smp_ready_in = 1'b1;
    d0 = done_cnt;
    push_exp(5, 2);
    start_job(32'h0010_0005, 16'd2);
    s0 = cyc;
    n = 0;
    while (!smp_valid_out && n < 20) begin samp(); n++; end
    chk("first_latency", 64'(cyc - s0), 64'd3);
    first = cyc;
    ref_load_done_in = 1'b0;  // dropping mid-job must not disturb it
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin samp(); n++; end
    chk("sustained_rate", 64'(cyc - first), 64'd9);
    ref_load_done_in = 1'b1;
    wait_idle("job_5x2", 100);
    chk("done_5x2", 64'(done_cnt - d0), 64'd1);
    chk("addr_hold_5x2", 64'(ref_addr_out), 64'd4);

    // len=8, passes=1, ready toggling then held low
    d0 = done_cnt;
    push_exp(8, 1);
    start_job(32'd8, 16'd1);
    for (int i = 0; i < 12; i++) begin
      smp_ready_in = (i % 2 == 0);
      tick();
    end
    smp_ready_in = 1'b0;
    repeat (10) tick();
    chk("stalled_valid", 64'(smp_valid_out), 64'd1);
    smp_ready_in = 1'b1;
    wait_idle("job_8x1", 100);
    chk("done_8x1", 64'(done_cnt - d0), 64'd1);
    chk("addr_hold_8x1", 64'(ref_addr_out), 64'd7);

    // Start while reference memory not loaded
    ref_load_done_in = 1'b0;
    d0 = done_cnt;
    start_job(32'd5, 16'd1);
    repeat (4) tick();
    chk("err_set", 64'(err_not_loaded_out), 64'd1);
    chk("err_busy", 64'(busy_out), 64'd0);
    chk("err_no_read", 64'(ref_addr_out), 64'd7);
    chk("err_no_done", 64'(done_cnt - d0), 64'd0);

    // Valid start clears the error; len=1 passes=1 gives one doubly-tagged sample
    ref_load_done_in = 1'b1;
    push_exp(1, 1);
    start_job(32'd1, 16'd1);
    samp();
    chk("err_cleared", 64'(err_not_loaded_out), 64'd0);
    wait_idle("job_1x1", 50);
    chk("done_1x1", 64'(done_cnt - d0), 64'd1);

    // Zero length / zero passes: immediate done pulse, no samples
    d0 = done_cnt;
    start_job(32'd0, 16'd3);
    samp();
    chk("len0_done_pulse", 64'(done_out), 64'd1);
    chk("len0_busy", 64'(busy_out), 64'd0);
    tick();
    samp();
    chk("len0_done_one_cycle", 64'(done_out), 64'd0);
    start_job(32'd4, 16'd0);
    samp();
    chk("pass0_done_pulse", 64'(done_out), 64'd1);
    repeat (3) tick();
    chk("zero_jobs_done_count", 64'(done_cnt - d0), 64'd2);

    // Abort and start in the same cycle: abort wins
    d0 = done_cnt;
    abort_in = 1'b1;
    start_job(32'd3, 16'd1);
    abort_in = 1'b0;
    repeat (4) tick();
    chk("abort_start_busy", 64'(busy_out), 64'd0);
    chk("abort_start_nodone", 64'(done_cnt - d0), 64'd0);

    // Abort mid-ISSUE with three samples buffered and ready low
    smp_ready_in = 1'b0;
    start_job(32'd8, 16'd1);
    repeat (5) tick();
    chk("pre_abort_valid", 64'(smp_valid_out), 64'd1);
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    chk("abort_valid_drop", 64'(smp_valid_out), 64'd0);
    chk("abort_busy", 64'(busy_out), 64'd0);
    repeat (6) tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_stays_empty", 64'(smp_valid_out), 64'd0);
    smp_ready_in = 1'b1;
    push_exp(3, 1);
    start_job(32'd3, 16'd1);
    wait_idle("job_after_abort", 50);
    chk("done_after_abort", 64'(done_cnt - d0), 64'd1);

    // Asynchronous reset mid-DRAIN
    smp_ready_in = 1'b0;
    start_job(32'd3, 16'd1);
    repeat (6) tick();
    chk("drain_busy", 64'(busy_out), 64'd1);
    chk("drain_valid", 64'(smp_valid_out), 64'd1);
    #1;
    rst_n_in = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 64'd0);
    repeat (2) tick();
    rst_n_in = 1'b1;
    tick();
    smp_ready_in = 1'b1;
    d0 = done_cnt;
    push_exp(4, 2);
    start_job(32'd4, 16'd2);
    wait_idle("job_after_reset", 100);
    chk("done_after_reset", 64'(done_cnt - d0), 64'd1);
    chk("addr_hold_4x2", 64'(ref_addr_out), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
